sync_fifo_flags: RTL

//   Single-clock FIFO with any depth (not limited to a power of two) and any width.

---
 rtl/sync_fifo_flags.sv | 89 ++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO of any depth with count, almost flags and sticky errors
// Optional build: define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_flags #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  input  logic             re,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rd,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    w_ptr;
  logic [PW-1:0]    r_ptr;
  logic             rd_acc;
  logic             wr_acc;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // A full FIFO still takes a write when the head word leaves in the same cycle.
  assign rd_acc = re && !empty;
  assign wr_acc = we && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= (w_ptr == LAST) ? '0 : w_ptr + 1'b1;
      if (rd_acc) r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A new error in the same cycle as clr_err keeps the flag set.
      if (we && !wr_acc)  overflow <= 1'b1;
      else if (clr_err)   overflow <= 1'b0;

      if (re && empty)    underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem[w_ptr] <= wd;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd       = mem[r_ptr];
  assign rd_valid = !empty;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      rd       <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd <= mem[r_ptr];
    end
  end
`endif

endmodule
